// File: rtl/key_vaild_ctrl_if.sv
// key_vaild_ctrl_if: button-side and LED-enable signals of the key controller.
// The slave modport is the controller; the master modport is whatever drives
// the raw key and consumes the enable/flags (board pin model, LED block).
interface key_vaild_ctrl_if;
  logic key_in;     // raw push-button, active-low, asynchronous
  logic vaild;      // LED enable level
  logic key_flag;   // one-cycle pulse per debounced press
  logic key_state;  // debounced level, 1 = released
  logic long_flag;  // one-cycle pulse on long-press detection

  modport master (
    output key_in,
    input  vaild,
    input  key_flag,
    input  key_state,
    input  long_flag
  );

  modport slave (
    input  key_in,
    output vaild,
    output key_flag,
    output key_state,
    output long_flag
  );
endinterface

// File: rtl/key_vaild_ctrl.sv
// key_vaild_ctrl: push-button debouncer that toggles the LED enable level
// `vaild` once per accepted press.
//
// Raw key -> two-flop synchroniser -> four-state debounce FSM
// (IDLE / P_FILT / DOWN / R_FILT). A press is accepted only after the key has
// been seen low for CNT_MAX consecutive cycles; any bounce back high restarts
// the filter, and a bounce on the terminal cycle still wins. Release is
// filtered the same way but raises no flag, so one physical press gives at
// most one key_flag.
//
// Optional feature, macro KEY_LONG_PRESS_EN: a hold of LONG_MAX cycles in DOWN
// pulses long_flag and forces vaild low. Without the macro there is no long
// counter, LONG_MAX is ignored and long_flag is tied low.
//
// All outputs come straight from flops; reset is synchronous, active-low.
module key_vaild_ctrl #(
  parameter int CNT_MAX  = 1_000_000,    // debounce window, >= 2
  parameter int LONG_MAX = 100_000_000   // long-press threshold, > CNT_MAX
) (
  input logic             sys_clk,
  input logic             rst_n,
  key_vaild_ctrl_if.slave kif
);

  localparam int            CW       = $clog2(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE,    // released, waiting for key low
    S_P_FILT,  // key low, counting the press window
    S_DOWN,    // press accepted, waiting for key high
    S_R_FILT   // key high, counting the release window
  } state_t;

  logic          key_s0;
  logic          key_sync;
  state_t        state,       state_nxt;
  logic [CW-1:0] cnt,         cnt_nxt;
  logic          vaild_q,     vaild_nxt;
  logic          key_flag_q,  key_flag_nxt;
  logic          key_state_q, key_state_nxt;

`ifdef KEY_LONG_PRESS_EN
  localparam int             LCW       = $clog2(LONG_MAX);
  localparam logic [LCW-1:0] LCNT_LAST = LCW'(LONG_MAX - 1);

  // lcnt saturates at LCNT_LAST; long_done remembers that the pulse for this
  // press has already been issued so the saturated count cannot re-fire it.
  logic [LCW-1:0] lcnt,        lcnt_nxt;
  logic           long_done,   long_done_nxt;
  logic           long_flag_q, long_flag_nxt;
`endif

  // Two-flop synchroniser for the asynchronous key pin; idles released (1).
  // NOTE: every flop is written with <= so all registers sample the values
  // from before the edge; a blocking = here would collapse the two stages
  // into one in simulation and leave key_in metastable-prone in silicon.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      key_s0   <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_s0   <= kif.key_in;
      key_sync <= key_s0;
    end
  end

  // Debounce FSM next-state, counters and registered-output next values.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    vaild_nxt    = vaild_q;
    key_flag_nxt = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (!key_sync) begin
          state_nxt = S_P_FILT;
          cnt_nxt   = '0;
        end
      end
      S_P_FILT: begin
        // A high sample is checked first so a bounce on the terminal cycle
        // rejects the press.
        if (key_sync) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt    = S_DOWN;
          cnt_nxt      = '0;
          key_flag_nxt = 1'b1;
          vaild_nxt    = ~vaild_q;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DOWN: begin
        if (key_sync) begin
          state_nxt = S_R_FILT;
          cnt_nxt   = '0;
        end
      end
      S_R_FILT: begin
        if (!key_sync) begin
          state_nxt = S_DOWN;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    key_state_nxt = (state_nxt == S_IDLE) || (state_nxt == S_P_FILT);

`ifdef KEY_LONG_PRESS_EN
    lcnt_nxt      = lcnt;
    long_done_nxt = long_done;
    long_flag_nxt = 1'b0;
    if (state == S_P_FILT && state_nxt == S_DOWN) begin
      // Fresh press: restart the hold timer. A return from R_FILT does not
      // take this path, so a release bounce resumes the count.
      lcnt_nxt      = '0;
      long_done_nxt = 1'b0;
    end else if (state == S_DOWN) begin
      if (lcnt == LCNT_LAST) begin
        if (!long_done) begin
          long_flag_nxt = 1'b1;
          long_done_nxt = 1'b1;
          vaild_nxt     = 1'b0;
        end
      end else begin
        lcnt_nxt = lcnt + 1'b1;
      end
    end
`endif
  end

  // FSM state, debounce counter and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      vaild_q     <= 1'b0;
      key_flag_q  <= 1'b0;
      key_state_q <= 1'b1;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      vaild_q     <= vaild_nxt;
      key_flag_q  <= key_flag_nxt;
      key_state_q <= key_state_nxt;
    end
  end

`ifdef KEY_LONG_PRESS_EN
  // Long-press hold timer and its one-shot pulse.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      lcnt        <= '0;
      long_done   <= 1'b0;
      long_flag_q <= 1'b0;
    end else begin
      lcnt        <= lcnt_nxt;
      long_done   <= long_done_nxt;
      long_flag_q <= long_flag_nxt;
    end
  end

  assign kif.long_flag = long_flag_q;
`else
  assign kif.long_flag = 1'b0;
`endif

  assign kif.vaild     = vaild_q;
  assign kif.key_flag  = key_flag_q;
  assign kif.key_state = key_state_q;

endmodule

// File: doc/key_vaild_ctrl.md
# key_vaild_ctrl

Debounces the board push-button and generates the `vaild` level that enables the LED stage directly downstream (the default-pattern LED block). It synchronises the raw active-low key, filters bounce with a four-state FSM, and toggles `vaild` once per debounced press. An optional long-press detector forces `vaild` low so the LEDs return to their default state.

## Interface
- `CNT_MAX`, 1_000_000 — debounce window in `sys_clk` cycles (20 ms at 50 MHz); legal range ≥ 2.
- `LONG_MAX`, 100_000_000 — long-press threshold in cycles (2 s at 50 MHz); must exceed `CNT_MAX`; used only with `KEY_LONG_PRESS_EN`.
- `sys_clk`  in  1  50 MHz system clock.
- `rst_n`  in  1  Reset, synchronous, active-low.
- `key_in`  in  1  Raw push-button, asynchronous, active-low (0 = pressed).
- `vaild`  out  1  LED enable level, toggled per debounced press; feeds the downstream LED block's `vaild`.
- `key_flag`  out  1  One-cycle pulse on each debounced press.
- `key_state`  out  1  Debounced key level, 1 = released, 0 = pressed.
- `long_flag`  out  1  One-cycle pulse on long-press detection; constant 0 when the feature is compiled out.

## Operation
- Synchroniser: two flops `key_in` → `key_s0` → `key_sync`, both reset to 1.
- Debounce counter `cnt` is `$clog2(CNT_MAX)` bits wide, cleared on every state change and never wraps; it saturates at `CNT_MAX-1`.
- FSM states and transitions:
  - IDLE (`key_state`=1): `key_sync`=0 → P_FILT with `cnt`=0.
  - P_FILT: `key_sync`=1 → IDLE, with `cnt` cleared (bounce rejected). Otherwise `cnt`++. When `cnt`==`CNT_MAX-1` and `key_sync`=0 → DOWN, with `key_flag`=1 and `vaild` toggled.
  - DOWN (`key_state`=0): `key_sync`=1 → R_FILT with `cnt`=0.
  - R_FILT: `key_sync`=0 → DOWN. Otherwise `cnt`++. When `cnt`==`CNT_MAX-1` → IDLE. No flag is raised on release.
- `key_state` is 0 in DOWN and R_FILT, and 1 in IDLE and P_FILT.
- Each physical press produces at most one `key_flag`, however long it is held or however much it bounces on release.
- If `key_sync` bounces on the same edge that `cnt` reaches terminal, the bounce wins: no press is accepted.

## Timing
- Reset values: `vaild`=0, `key_flag`=0, `key_state`=1, `long_flag`=0, FSM=IDLE, all counters 0, synchroniser flops 1.
- Reset has priority over all other events, including a press in progress. After reset is released, a key still held must pass a full debounce from IDLE before it is accepted.
- Press latency: `key_in` is held low and stable, and the first edge that samples it low is edge S. Then `key_flag` and the new `vaild` value are registered at edge S+`CNT_MAX`+2.
- `key_flag` and `long_flag` are high for exactly one cycle.
- `vaild` changes only on the cycle `key_flag` is high, or on the cycle `long_flag` is high.
- Release latency: `key_state` returns to 1 at edge R+`CNT_MAX`+2, where R is the first edge that samples `key_in` high.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `KEY_LONG_PRESS_EN` defined:
  - A `$clog2(LONG_MAX)`-bit counter `lcnt` is cleared on entry to DOWN and increments every cycle in DOWN.
  - `lcnt` holds its value in R_FILT and resumes counting on a return to DOWN.
  - At `lcnt`==`LONG_MAX-1` in DOWN: `long_flag`=1 for one cycle and `vaild` is forced to 0, irrespective of its current value.
  - `lcnt` then saturates, so there is at most one `long_flag` per press.
  - The short-press toggle at debounce still occurs first.
- `KEY_LONG_PRESS_EN` undefined:
  - No `lcnt` register exists and `long_flag` is tied to 0.
  - `LONG_MAX` is ignored.
  - `vaild` changes only by toggling.

## Test plan
Test parameters: `CNT_MAX`=8, `LONG_MAX`=32.
- Hold `rst_n`=0 for 3 cycles with `key_in`=0 → all outputs stay at their reset values. After release with the key still low, `key_flag` fires at edge 10 after release; edge S is the first post-reset edge.
- Clean press, `key_in` low for 20 cycles from edge S → `key_flag` pulses at S+10 and `vaild` goes 0→1. Release → `key_state`=1 at R+10. No second flag.
- Bouncy press, `key_in` toggling every 3 cycles for 30 cycles then stable low → no `key_flag` during the bounce; exactly one `key_flag` 10 cycles after the last bounce.
- Two separate clean presses → `vaild` sequence 0→1→0, with one `key_flag` each.
- `KEY_LONG_PRESS_EN` set, key held 50 cycles → `key_flag` at S+10 (`vaild`=1), then `long_flag` 32 cycles after DOWN entry (`vaild`=0). Only one `long_flag`.
- Reset asserted in DOWN with `vaild`=1 → the next edge gives `vaild`=0 and `key_state`=1, with no flags.
